// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Two-port (CPU / loader) arbiter driving a single-cycle-strobe memory.      |
// | Optional: define MEM_ARB_RR_EN for round-robin on simultaneous requests.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_data_oe
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    logic   r_sel_b;
    logic   r_we;
    logic   w_any_req;
    logic   w_pick_b;
    logic   w_start;

`ifdef MEM_ARB_RR_EN
    logic   r_last_b;
`endif

    always_comb begin
        w_any_req = a_req | b_req;
`ifdef MEM_ARB_RR_EN
        // Tie goes to whichever port was not served most recently.
        if (a_req && b_req) begin
            w_pick_b = ~r_last_b;
        end else begin
            w_pick_b = ~a_req;
        end
`else
        w_pick_b  = ~a_req;
`endif
        // Grant is a same-cycle response to req in IDLE, so it cannot be registered.
        w_start   = (r_state == S_IDLE) && w_any_req && !rst;
        a_gnt     = w_start && !w_pick_b;
        b_gnt     = w_start && w_pick_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel_b     <= 1'b0;
            r_we        <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_data_oe <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            rdata       <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_b    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_SETUP;
                        r_sel_b     <= w_pick_b;
                        r_we        <= w_pick_b ? b_we    : a_we;
                        mem_addr    <= w_pick_b ? b_addr  : a_addr;
                        mem_wdata   <= w_pick_b ? b_wdata : a_wdata;
                        mem_data_oe <= w_pick_b ? b_we    : a_we;
`ifdef MEM_ARB_RR_EN
                        r_last_b    <= w_pick_b;
`endif
                    end
                end
                S_SETUP: begin
                    r_state   <= S_STROBE;
                    mem_read  <= ~r_we;
                    mem_write <= r_we;
                end
                S_STROBE: begin
                    r_state   <= S_DONE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!r_we) begin
                        rdata <= mem_rdata;
                    end
                    a_done    <= ~r_sel_b;
                    b_done    <= r_sel_b;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    a_done      <= 1'b0;
                    b_done      <= 1'b0;
                    mem_data_oe <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
